// File: rtl/seg_scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_pkg
//   Shared definitions for the 7-segment receive path.
//   - SEG_0..SEG_F, SEG_NULL: active-low segment patterns {dp,g,f,e,d,c,b,a}
//     with the decimal point off. Display drivers use the same constants, so
//     encoder and decoder always agree on one table.
//   - sel_kind_e / classify_sel: classification of a digit-select word.
// -----------------------------------------------------------------------------
package seg_scan_decoder_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_A    = 8'h88;
  localparam logic [7:0] SEG_B    = 8'h83;
  localparam logic [7:0] SEG_C    = 8'hC6;
  localparam logic [7:0] SEG_D    = 8'hA1;
  localparam logic [7:0] SEG_E    = 8'h86;
  localparam logic [7:0] SEG_F    = 8'h8E;
  localparam logic [7:0] SEG_NULL = 8'hFF;

  // Indexed by nibble value.
  localparam logic [7:0] SEG_HEX [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    SEL_NONE,   // 8'h00: scan dead time
    SEL_ONE,    // exactly one digit selected
    SEL_ALL,    // 8'hFF: static drive, all digits show the same pattern
    SEL_MULTI   // anything else: bus fault
  } sel_kind_e;

  function automatic sel_kind_e classify_sel(input logic [7:0] sel);
    if (sel == 8'h00) return SEL_NONE;
    if (sel == 8'hFF) return SEL_ALL;
    // Clearing the lowest set bit leaves zero only for a one-hot word.
    if ((sel & (sel - 8'd1)) == 8'h00) return SEL_ONE;
    return SEL_MULTI;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_if
//   Snooped display bus plus the recovered frame.
//   Bus (driven by the display side / master):
//     seg_in[7:0]  segment lines, active-low, [6:0]=g..a, [7]=dp
//     sel_in[7:0]  digit select, active-high, 8'hFF = static drive
//   Recovered frame (driven by the decoder / slave):
//     digits[31:0] nibble of digit i at [4i+3:4i]
//     dp, blank, digit_err [7:0] per-digit flags
//     frame_valid, sel_err, timeout  single-cycle pulses
// -----------------------------------------------------------------------------
interface seg_scan_decoder_if;
  logic [7:0]  seg_in;
  logic [7:0]  sel_in;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        sel_err;
  logic        timeout;

  modport master (
    output seg_in, sel_in,
    input  digits, dp, blank, digit_err, frame_valid, sel_err, timeout
  );

  modport slave (
    input  seg_in, sel_in,
    output digits, dp, blank, digit_err, frame_valid, sel_err, timeout
  );
endinterface

// File: rtl/seg_scan_decoder_seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_seg7_pattern_decode
//   Combinational seg[6:0] -> {err, blank, nibble}.
//   Ports:
//     seg[6:0]    in   active-low segments g..a (dp is handled by the caller)
//     nibble[3:0] out  hex value, 0 for blank or unknown patterns
//     blank       out  all segments off
//     err         out  pattern is neither blank nor in the hex table
// -----------------------------------------------------------------------------
module seg_scan_decoder_seg7_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b1;
    if (seg == SEG_NULL[6:0]) begin
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_HEX[i][6:0]) begin
          nibble = 4'(i);
          err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//   Receive side of an 8-digit 7-segment display bus. Samples seg/sel driven by
//   a static or scanned display driver and rebuilds one frame per 8 digits.
//   Parameters:
//     STABLE_CYC   identical synced {sel,seg} cycles before a sample is taken
//     TIMEOUT_CYC  idle cycles after which a partial frame is dropped
//   Ports:
//     sys_clk, sys_rst_n (async, active-low)
//     bus  seg_scan_decoder_if.slave (seg_in/sel_in in, frame outputs out)
// -----------------------------------------------------------------------------
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam int unsigned       STAB_W    = $clog2(STABLE_CYC);
  localparam int unsigned       TO_W      = $clog2(TIMEOUT_CYC);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(STABLE_CYC - 2);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [7:0]        seg_s1_q, seg_s2_q, seg_prev_q;
  logic [7:0]        sel_s1_q, sel_s2_q, sel_prev_q;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        mask_q, mask_d;
  logic [31:0]       sh_digits_q, sh_digits_d;
  logic [7:0]        sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [31:0]       digits_q, digits_d;
  logic [7:0]        dp_q, dp_d, blank_q, blank_d, derr_q, derr_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sel_err_q, sel_err_d;
  logic              timeout_q, timeout_d;

  logic              capture, valid_cap, frame_done;
  logic [3:0]        dec_nib;
  logic              dec_blank, dec_err;
  sel_kind_e         sel_kind;

  seg_scan_decoder_seg7_pattern_decode u_decode (
    .seg    (seg_s2_q[6:0]),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  assign sel_kind = classify_sel(sel_s2_q);

  // Stability filter: one capture per stable interval. The counter parks at
  // STAB_LAST, so a held value never produces a second capture.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    capture    = 1'b0;
    if ({sel_s2_q, seg_s2_q} != {sel_prev_q, seg_prev_q}) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_LAST) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
      capture    = (stab_cnt_q == STAB_PRE);
    end
  end

  assign valid_cap  = capture && ((sel_kind == SEL_ONE) || (sel_kind == SEL_ALL));
  assign frame_done = (mask_q == 8'hFF);

  always_comb begin
    mask_d        = mask_q;
    to_cnt_d      = to_cnt_q;
    sh_digits_d   = sh_digits_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    sh_err_d      = sh_err_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    blank_d       = blank_q;
    derr_d        = derr_q;
    frame_valid_d = 1'b0;
    sel_err_d     = capture && (sel_kind == SEL_MULTI);
    timeout_d     = 1'b0;

    // Mask filled on the previous capture: publish the shadow frame.
    if (frame_done) begin
      digits_d      = sh_digits_q;
      dp_d          = sh_dp_q;
      blank_d       = sh_blank_q;
      derr_d        = sh_err_q;
      frame_valid_d = 1'b1;
      mask_d        = 8'h00;
    end

    // A valid capture restarts the idle timer and wins over a timeout.
    // Dead-time (sel=00) and multi-hot captures leave the timer running.
    if (valid_cap) begin
      to_cnt_d = '0;
      for (int i = 0; i < 8; i++) begin
        if (sel_s2_q[i]) begin
          sh_digits_d[4*i +: 4] = dec_nib;
          sh_dp_d[i]            = ~seg_s2_q[7];
          sh_blank_d[i]         = dec_blank;
          sh_err_d[i]           = dec_err;
          mask_d[i]             = 1'b1;
        end
      end
    end else if (!frame_done && (mask_q != 8'h00)) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_d = 1'b1;
        mask_d    = 8'h00;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_s1_q      <= '0;
      seg_s2_q      <= '0;
      seg_prev_q    <= '0;
      sel_s1_q      <= '0;
      sel_s2_q      <= '0;
      sel_prev_q    <= '0;
      stab_cnt_q    <= '0;
      to_cnt_q      <= '0;
      mask_q        <= '0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      sh_err_q      <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      derr_q        <= '0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // Bus pins are asynchronous to sys_clk: two-flop synchronizers.
      seg_s1_q      <= bus.seg_in;
      seg_s2_q      <= seg_s1_q;
      seg_prev_q    <= seg_s2_q;
      sel_s1_q      <= bus.sel_in;
      sel_s2_q      <= sel_s1_q;
      sel_prev_q    <= sel_s2_q;
      stab_cnt_q    <= stab_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_err_q      <= sh_err_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      derr_q        <= derr_d;
      frame_valid_q <= frame_valid_d;
      sel_err_q     <= sel_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.digit_err   = derr_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder with STABLE_CYC=4, TIMEOUT_CYC=64.
//   A static-drive decode table is applied in a loop; scan, glitch, error,
//   timeout and mid-frame reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int STABLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 64;

  localparam logic [7:0] TB_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [7:0] seg;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       err;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .STABLE_CYC  (STABLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  int se_cnt = 0;

  always @(negedge sys_clk) begin
    if (bus.frame_valid) fv_cnt++;
    if (bus.timeout)     to_cnt++;
    if (bus.sel_err)     se_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic put(input logic [7:0] sel, input logic [7:0] seg, input int n);
    bus.sel_in = sel;
    bus.seg_in = seg;
    wait_cyc(n);
  endtask

  function automatic logic [7:0] pat(input logic [3:0] n, input logic dp_on);
    logic [7:0] p;
    p = TB_SEG[n];
    return {~dp_on, p[6:0]};
  endfunction

  task automatic scan_digits(input int first, input int last,
                             input logic [31:0] val, input logic [7:0] dps);
    for (int i = first; i <= last; i++)
      put(8'(1 << i), pat(val[4*i +: 4], dps[i]), 10);
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] d, input logic [7:0] p,
                           input logic [7:0] b, input logic [7:0] e);
    chk({tag, "_digits"}, bus.digits, d);
    chk({tag, "_dp"},     {24'h0, bus.dp}, {24'h0, p});
    chk({tag, "_blank"},  {24'h0, bus.blank}, {24'h0, b});
    chk({tag, "_err"},    {24'h0, bus.digit_err}, {24'h0, e});
  endtask

  vec_t vt [20];

  initial begin
    int fv0, to0, se0;

    vt[0]  = '{8'hC0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{8'hF9, 4'h1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{8'h24, 4'h2, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{8'hB0, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{8'h99, 4'h4, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{8'h12, 4'h5, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'h82, 4'h6, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{8'hF8, 4'h7, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{8'h80, 4'h8, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{8'h90, 4'h9, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'h88, 4'hA, 1'b0, 1'b0, 1'b0};
    vt[11] = '{8'h83, 4'hB, 1'b0, 1'b0, 1'b0};
    vt[12] = '{8'hC6, 4'hC, 1'b0, 1'b0, 1'b0};
    vt[13] = '{8'hA1, 4'hD, 1'b0, 1'b0, 1'b0};
    vt[14] = '{8'h86, 4'hE, 1'b0, 1'b0, 1'b0};
    vt[15] = '{8'h0E, 4'hF, 1'b1, 1'b0, 1'b0};
    vt[16] = '{8'hFF, 4'h0, 1'b0, 1'b1, 1'b0};
    vt[17] = '{8'h7F, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[18] = '{8'hD5, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[19] = '{8'h00, 4'h8, 1'b1, 1'b0, 1'b0};

    // Reset state
    bus.sel_in = 8'h00;
    bus.seg_in = 8'hFF;
    wait_cyc(3);
    chk_frame("rst", 32'h0, 8'h00, 8'h00, 8'h00);
    chk("rst_fv", {31'h0, bus.frame_valid}, 32'h0);
    chk("rst_selerr", {31'h0, bus.sel_err}, 32'h0);
    chk("rst_timeout", {31'h0, bus.timeout}, 32'h0);
    sys_rst_n = 1'b1;
    wait_cyc(2);

    // Static drive, exact latency, no repeat while held
    fv0 = fv_cnt;
    put(8'hFF, 8'hA4, 6);
    chk("static_fv_early", {31'h0, bus.frame_valid}, 32'h0);
    wait_cyc(1);
    chk("static_fv_pulse", {31'h0, bus.frame_valid}, 32'h1);
    chk_frame("static", 32'h2222_2222, 8'h00, 8'h00, 8'h00);
    wait_cyc(13);
    chk("static_fv_once", 32'(fv_cnt - fv0), 32'h1);

    // Decode table on static drive
    for (int k = 0; k < 20; k++) begin
      fv0 = fv_cnt;
      put(8'hFF, vt[k].seg, 12);
      chk($sformatf("tbl%0d_fv", k), 32'(fv_cnt - fv0), 32'h1);
      chk_frame($sformatf("tbl%0d", k), {8{vt[k].nib}}, {8{vt[k].dp}},
                {8{vt[k].blank}}, {8{vt[k].err}});
    end

    // Scanned frame 1..8, dp on digit 3
    fv0 = fv_cnt;
    scan_digits(0, 7, 32'h8765_4321, 8'h08);
    chk("scan_fv", 32'(fv_cnt - fv0), 32'h1);
    chk_frame("scan", 32'h8765_4321, 8'h08, 8'h00, 8'h00);

    // Idle with empty mask: no timeout
    to0 = to_cnt;
    put(8'h00, 8'hFF, 100);
    chk("idle_no_timeout", 32'(to_cnt - to0), 32'h0);

    // Glitching segments on digit 0 must not capture until settled
    scan_digits(1, 7, 32'hFEDC_BA90, 8'h00);
    fv0 = fv_cnt;
    for (int k = 0; k < 10; k++) put(8'h01, (k % 2) ? 8'hC0 : 8'hF9, 1);
    chk("glitch_no_capture", 32'(fv_cnt - fv0), 32'h0);
    put(8'h01, 8'hC6, 6);
    chk("glitch_fv_early", {31'h0, bus.frame_valid}, 32'h0);
    wait_cyc(1);
    chk("glitch_fv_pulse", {31'h0, bus.frame_valid}, 32'h1);
    chk("glitch_digits", bus.digits, 32'hFEDC_BA9C);
    wait_cyc(10);
    chk("glitch_fv_once", 32'(fv_cnt - fv0), 32'h1);

    // Multi-hot select, blank and unknown patterns
    fv0 = fv_cnt;
    se0 = se_cnt;
    scan_digits(0, 3, 32'h0000_BCDE, 8'h00);
    put(8'h03, 8'h99, 10);
    chk("selerr_pulse", 32'(se_cnt - se0), 32'h1);
    chk("selerr_no_frame", 32'(fv_cnt - fv0), 32'h0);
    put(8'h10, pat(4'hA, 1'b0), 10);
    put(8'h20, 8'h7F, 10);
    put(8'h40, 8'h55, 10);
    put(8'h80, pat(4'h9, 1'b0), 10);
    chk("err_fv", 32'(fv_cnt - fv0), 32'h1);
    chk_frame("err", 32'h900A_BCDE, 8'h60, 8'h20, 8'h40);

    // Timeout of a partial frame
    fv0 = fv_cnt;
    to0 = to_cnt;
    scan_digits(0, 2, 32'h0000_0777, 8'h00);
    put(8'h00, 8'hFF, 50);
    chk("timeout_not_yet", 32'(to_cnt - to0), 32'h0);
    wait_cyc(20);
    chk("timeout_pulse", 32'(to_cnt - to0), 32'h1);
    chk("timeout_no_frame", 32'(fv_cnt - fv0), 32'h0);
    chk_frame("timeout_hold", 32'h900A_BCDE, 8'h60, 8'h20, 8'h40);
    scan_digits(3, 7, 32'h0F1E_2D3C, 8'h81);
    chk("timeout_mask_cleared", 32'(fv_cnt - fv0), 32'h0);
    scan_digits(0, 2, 32'h0F1E_2D3C, 8'h81);
    chk("after_timeout_fv", 32'(fv_cnt - fv0), 32'h1);
    chk_frame("after_timeout", 32'h0F1E_2D3C, 8'h81, 8'h00, 8'h00);

    // Reset in the middle of a frame
    scan_digits(0, 3, 32'h1111_2222, 8'h00);
    sys_rst_n = 1'b0;
    #1;
    chk_frame("midrst", 32'h0, 8'h00, 8'h00, 8'h00);
    put(8'h00, 8'hFF, 3);
    sys_rst_n = 1'b1;
    wait_cyc(2);
    fv0 = fv_cnt;
    scan_digits(4, 7, 32'h1357_9BDF, 8'h24);
    chk("midrst_partial", 32'(fv_cnt - fv0), 32'h0);
    scan_digits(0, 3, 32'h1357_9BDF, 8'h24);
    chk("midrst_fv", 32'(fv_cnt - fv0), 32'h1);
    chk_frame("midrst_frame", 32'h1357_9BDF, 8'h24, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
